disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It holds a double-buffered display value and steps through the digits one at a time. For each digit it drives the matching active-low anode and the decoded segment pattern. Each digit slot starts with a short blanking gap to suppress ghosting. The block sits between system logic (load/value) and the board display pins, and it contains the shared hex_to_7seg decoder.

---
 rtl/disp_scan_ctrl_pkg.sv | 23 ++
 rtl/disp_scan_ctrl_if.sv | 21 ++
 rtl/hex_to_7seg.sv | 37 +++
 rtl/disp_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Ceiling log2, never less than 1 so counters always have a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// System-side and display-side signals of the scan controller.
interface disp_scan_if #(parameter int N_DIGITS = 4);
  logic                  enable;
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  lz_en;
  logic [N_DIGITS-1:0]   an;
  logic [7:0]            sseg;
  logic                  frame_done;

  modport master (
    output enable, load, value, dp_in, lz_en,
    input  an, sseg, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, lz_en,
    output an, sseg, frame_done
  );
endinterface

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern; bit 7 is the decimal point.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] gfedcba;

  always_comb begin
    gfedcba = 7'h7F;
    case (nibble)
      4'h0: gfedcba = 7'h40;
      4'h1: gfedcba = 7'h79;
      4'h2: gfedcba = 7'h24;
      4'h3: gfedcba = 7'h30;
      4'h4: gfedcba = 7'h19;
      4'h5: gfedcba = 7'h12;
      4'h6: gfedcba = 7'h02;
      4'h7: gfedcba = 7'h78;
      4'h8: gfedcba = 7'h00;
      4'h9: gfedcba = 7'h10;
      4'hA: gfedcba = 7'h08;
      4'hB: gfedcba = 7'h03;
      4'hC: gfedcba = 7'h46;
      4'hD: gfedcba = 7'h21;
      4'hE: gfedcba = 7'h06;
      4'hF: gfedcba = 7'h0E;
      default: gfedcba = 7'h7F;
    endcase
  end

  assign seg = {~dp, gfedcba};

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed N-digit common-anode display scanner with double-buffered value.
//
//   state | meaning
//   IDLE  | scan disabled, display dark
//   BLANK | slot start, all anodes off to suppress ghosting
//   SHOW  | current digit driven
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
)(
  input  logic        clk,
  input  logic        reset,
  disp_scan_if.slave  bus
);

  localparam int CW = clog2(PRESCALE);
  localparam int IW = clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam scan_state_t   SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

  scan_state_t            state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]  pend_val, act_val, next_val;
  logic [N_DIGITS-1:0]    pend_dp, act_dp, next_dp;
  logic [N_DIGITS-1:0]    an_q, an_d, supp;
  logic [7:0]             sseg_q, sseg_d, seg_dec;
  logic                   fd_q, commit, wrap, run;
  logic [3:0]             nib;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      an_q     <= AN_OFF[N_DIGITS-1:0];
      sseg_q   <= SEG_OFF;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      fd_q    <= wrap;
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      if (commit) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    wrap    = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
          idx_d   = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = SLOT_START;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              commit = 1'b1;
              wrap   = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output path looks at the buffer as it will be after this edge's commit.
  assign next_val = commit ? pend_val : act_val;
  assign next_dp  = commit ? pend_dp  : act_dp;
  assign nib      = next_val[{idx_d, 2'b00} +: 4];

  always_comb begin
    supp = '0;
    run  = bus.lz_en;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (run && (next_val[4*i +: 4] == 4'h0) && !next_dp[i]) supp[i] = 1'b1;
      else run = 1'b0;
    end
  end

  hex_to_7seg u_dec (
    .nibble (nib),
    .dp     (next_dp[idx_d]),
    .seg    (seg_dec)
  );

  always_comb begin
    an_d   = AN_OFF[N_DIGITS-1:0];
    sseg_d = SEG_OFF;
    if (state_d == SHOW && !supp[idx_d]) begin
      an_d[idx_d] = 1'b0;
      sseg_d      = seg_dec;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with N_DIGITS=4, PRESCALE=8, BLANK_CYC=2.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  disp_scan_if #(.N_DIGITS(4)) bus ();

  disp_scan_ctrl #(.N_DIGITS(4), .PRESCALE(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One 32-cycle frame; digit k expects an_x[4k+:4] / seg_x[8k+:8] after its 2 dark cycles.
  task automatic run_frame(input string nm, input logic [15:0] an_x, input logic [31:0] seg_x,
                           input logic fd_first, input int ld_at, input logic [15:0] ld_v);
    for (int c = 0; c < 32; c++) begin
      if (c == ld_at) begin
        bus.value = ld_v;
        bus.load  = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      if ((c % 8) < 2) begin
        chk($sformatf("%s_c%0d_an", nm, c), 32'(bus.an), 32'hF);
        chk($sformatf("%s_c%0d_seg", nm, c), 32'(bus.sseg), 32'hFF);
      end else begin
        chk($sformatf("%s_c%0d_an", nm, c), 32'(bus.an), 32'(an_x[4*(c/8) +: 4]));
        chk($sformatf("%s_c%0d_seg", nm, c), 32'(bus.sseg), 32'(seg_x[8*(c/8) +: 8]));
      end
      chk($sformatf("%s_c%0d_fd", nm, c), 32'(bus.frame_done), (c == 0) ? 32'(fd_first) : 32'h0);
    end
  endtask

  task automatic restart(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    bus.enable = 1'b0;
    tick();
    chk("dis_an", 32'(bus.an), 32'hF);
    chk("dis_fd", 32'(bus.frame_done), 32'h0);
    bus.value = v;
    bus.dp_in = dp;
    bus.load  = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.lz_en  = lz;
    bus.enable = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.dp_in  = '0;
    bus.lz_en  = 1'b0;
    #1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.sseg), 32'hFF);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_an", 32'(bus.an), 32'hF);
      chk("idle_seg", 32'(bus.sseg), 32'hFF);
    end

    // 12AF, plain scan, two frames
    bus.value = 16'h12AF;
    bus.load  = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    run_frame("h12af_f0", 16'h7BDE, 32'hF9A4888E, 1'b0, -1, 16'h0);
    run_frame("h12af_f1", 16'h7BDE, 32'hF9A4888E, 1'b1, -1, 16'h0);

    // leading-zero suppression
    restart(16'h0005, 4'b0000, 1'b1);
    run_frame("lz5", 16'hFFFE, 32'hFFFFFF92, 1'b0, -1, 16'h0);
    restart(16'h0000, 4'b0000, 1'b1);
    run_frame("lz0", 16'hFFFE, 32'hFFFFFFC0, 1'b0, -1, 16'h0);
    restart(16'h0000, 4'b0100, 1'b1);
    run_frame("lzdp", 16'hFBDE, 32'hFF40C0C0, 1'b0, -1, 16'h0);

    // double buffering: mid-frame load, then load on the commit edge
    restart(16'h0000, 4'b0000, 1'b0);
    run_frame("buf_a", 16'h7BDE, 32'hC0C0C0C0, 1'b0, 10, 16'h1111);
    run_frame("buf_b", 16'h7BDE, 32'hF9F9F9F9, 1'b1, 0, 16'h2222);
    run_frame("buf_c", 16'h7BDE, 32'hA4A4A4A4, 1'b1, -1, 16'h0);

    // enable dropped in digit 2 SHOW
    restart(16'h12AF, 4'b0000, 1'b0);
    repeat (20) tick();
    chk("d2_an", 32'(bus.an), 32'hB);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("off_an", 32'(bus.an), 32'hF);
      chk("off_seg", 32'(bus.sseg), 32'hFF);
      chk("off_fd", 32'(bus.frame_done), 32'h0);
    end
    bus.enable = 1'b1;
    run_frame("reen_f0", 16'h7BDE, 32'hF9A4888E, 1'b0, -1, 16'h0);
    run_frame("reen_f1", 16'h7BDE, 32'hF9A4888E, 1'b1, -1, 16'h0);

    // asynchronous reset in the middle of digit 0 SHOW
    repeat (4) tick();
    chk("pre_rst_an", 32'(bus.an), 32'hE);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_an", 32'(bus.an), 32'hF);
    chk("arst_seg", 32'(bus.sseg), 32'hFF);
    chk("arst_fd", 32'(bus.frame_done), 32'h0);
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_an", 32'(bus.an), 32'hF);
      chk("post_rst_seg", 32'(bus.sseg), 32'hFF);
    end
    bus.enable = 1'b1;
    run_frame("post_rst", 16'h7BDE, 32'hC0C0C0C0, 1'b0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
